note_audio_i2s: RTL and testbench

//  Downstream stage of the melody FSM. Turns the 22-bit note divider into a square-wave

---
 rtl/note_audio_i2s.sv | 145 ++++++++++++++
 tb/tb_note_audio_i2s.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_audio_i2s.sv
// -----------------------------------------------------------------------------
// note_audio_i2s
//
// Purpose:
//   Takes the note period from the melody FSM and produces a square-wave tone
//   with a selectable volume. The tone is serialised onto a Pmod I2S DAC, and
//   the same sample value feeds both the left and the right channel.
//
// Parameters:
//   DIV_W     width of note_div; the tone period in clk cycles (0 = silence)
//   AMP_STEP  amplitude added per volume step
//
// Ports:
//   clk       100 MHz system clock
//   rst       asynchronous, active-high reset
//   en        1 = play; 0 = silence, with the tone counter held at 0
//   note_div  tone period in clk cycles
//   vol       volume 0..7; amplitude = vol * AMP_STEP
//   mclk      I2S master clock, clk/4
//   lrck      word select, clk/512 (0 = left)
//   sck       serial bit clock, clk/16
//   sdin      serial data, I2S format, MSB first
// -----------------------------------------------------------------------------
module note_audio_i2s #(
  parameter int          DIV_W    = 22,
  parameter logic [15:0] AMP_STEP = 16'h1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] note_div,
  input  logic [2:0]       vol,
  output logic             mclk,
  output logic             lrck,
  output logic             sck,
  output logic             sdin
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  // ---------------------------------------------------------------------------
  // Free-running clock divider; all I2S clocks are taps of it
  // ---------------------------------------------------------------------------
  logic [8:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 9'd1;
    end
  end

  assign mclk = div_cnt[1];
  assign sck  = div_cnt[3];
  assign lrck = div_cnt[8];

  // ---------------------------------------------------------------------------
  // Tone generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] note_q;
  logic [DIV_W-1:0] tone_cnt;
  logic             note_short;
  logic             period_end;
  logic             note_load;

  // A period shorter than 2 cycles cannot form a square wave. It is treated as
  // silence, and it also keeps the latch open so a new note takes effect at once.
  assign note_short = (note_q < TWO);
  assign period_end = (tone_cnt == (note_q - ONE));
  assign note_load  = note_short | period_end;

  // note_q only changes at a period boundary. A new note_div that arrives
  // mid-period therefore never shortens or stretches the half-wave in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_q   <= '0;
      tone_cnt <= '0;
    end else if (!en) begin
      note_q   <= '0;
      tone_cnt <= '0;
    end else begin
      if (note_load) begin
        note_q   <= note_div;
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample value: +amp in the first floor(period/2) cycles, -amp after that
  // ---------------------------------------------------------------------------
  logic        phase_high;
  logic [15:0] amp;
  logic [15:0] sample;

  assign phase_high = (tone_cnt < (note_q >> 1));
  assign amp        = 16'(vol) * AMP_STEP;

  always_comb begin
    sample = 16'h0000;
    if (!note_short && (vol != 3'd0)) begin
      if (phase_high) begin
        sample = amp;
      end else begin
        sample = 16'h0000 - amp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // I2S serialiser
  //
  // Each lrck half holds 16 sck slots. sdin changes on the clk that ends a slot,
  // which is also where sck falls. At the end of slot 0 the fresh sample's MSB
  // goes straight to sdin, and sreg keeps the rest, already shifted by one.
  // This places bit15 in slot 1 and bit1 in slot 15. Bit0 then appears in
  // slot 0 of the following half, which gives the standard one-sck I2S delay.
  // ---------------------------------------------------------------------------
  logic [15:0] sreg;
  logic        slot_end;
  logic        word_load;

  assign slot_end  = (div_cnt[3:0] == 4'hF);
  assign word_load = (div_cnt[7:0] == 8'h0F);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      sdin <= 1'b0;
    end else if (slot_end) begin
      if (word_load) begin
        sdin <= sample[15];
        sreg <= {sample[14:0], 1'b0};
      end else begin
        sdin <= sreg[15];
        sreg <= {sreg[14:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_note_audio_i2s.sv
module tb_note_audio_i2s;

  localparam int DIV_W = 22;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [DIV_W-1:0] note_div = '0;
  logic [2:0]       vol = 3'd0;
  logic             mclk, lrck, sck, sdin;

  note_audio_i2s #(.DIV_W(DIV_W), .AMP_STEP(16'h1000)) dut (
    .clk(clk), .rst(rst), .en(en), .note_div(note_div), .vol(vol),
    .mclk(mclk), .lrck(lrck), .sck(sck), .sdin(sdin)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // The reference model works in absolute time. m_edge is the number of clock
  // edges since reset, m_start is the edge where the current period began, and
  // m_per is the period now in force.
  int          m_edge = 0;
  int          m_start = 0;
  int          m_per = 0;
  logic [15:0] w_cur = 16'h0;

  function automatic logic [15:0] exp_sample(int per, int el, logic [2:0] v);
    logic [15:0] a;
    a = 16'(int'(v) * 4096);
    if (per < 2 || v == 3'd0) return 16'h0000;
    if (el < per / 2) return a;
    return 16'h0000 - a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge  <= 0;
      m_start <= 0;
      m_per   <= 0;
      w_cur   <= 16'h0;
    end else begin
      if (m_edge % 256 == 15) w_cur <= exp_sample(m_per, m_edge - m_start, vol);
      m_edge <= m_edge + 1;
      if (!en) begin
        m_per   <= 0;
        m_start <= m_edge + 1;
      end else if (m_per < 2 || (m_edge - m_start) == m_per - 1) begin
        m_per   <= int'(note_div);
        m_start <= m_edge + 1;
      end
    end
  end

  // Per-cycle compare process and I2S word decoder
  logic        prev_sck = 1'b0;
  int          nbits = 0;
  logic [15:0] acc = 16'h0;
  logic [15:0] word;
  int          words_total = 0;
  int          words_nz = 0;
  bit          seen_3000, seen_d000, seen_7000, seen_9000;
  logic [8:0]  d;
  int          p;
  logic        eb;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      nbits    = 0;
      prev_sck = 1'b0;
    end else begin
      d = 9'(m_edge % 512);
      p = int'(d[7:4]);
      check("clocks", {29'd0, mclk, sck, lrck}, {29'd0, d[1], d[3], d[8]});
      check("sample", dut.sample, exp_sample(m_per, m_edge - m_start, vol));
      eb = (p == 0) ? w_cur[0] : w_cur[16 - p];
      check("sdin", sdin, eb);
      if (!prev_sck && sck) begin
        if (p == 1) begin
          acc   = {15'd0, sdin};
          nbits = 1;
        end else if (p >= 2 && nbits == p - 1) begin
          acc   = {acc[14:0], sdin};
          nbits = nbits + 1;
        end else if (p == 0 && nbits == 15) begin
          word = {acc[14:0], sdin};
          check("decoded_word", word, w_cur);
          words_total++;
          if (word != 16'h0) words_nz++;
          if (word == 16'h3000) seen_3000 = 1;
          if (word == 16'hD000) seen_d000 = 1;
          if (word == 16'h7000) seen_7000 = 1;
          if (word == 16'h9000) seen_9000 = 1;
          nbits = 0;
        end else begin
          nbits = 0;
        end
      end
      prev_sck = sck;
    end
  end

  // Waits for the sample to step from 'from' to 'to', with a bounded cycle budget.
  task automatic wait_edge(input logic [15:0] from, input logic [15:0] to, output int t);
    logic [15:0] prv, cur;
    @(posedge clk); #2;
    prv = dut.sample;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      cur = dut.sample;
      if (prv == from && cur == to) begin
        t = cyc;
        return;
      end
      prv = cur;
    end
    t = cyc;
    check("wait_edge_timeout", 32'd1, 32'd0);
  endtask

  task automatic quiet_window(input string name);
    int t0, z0;
    t0 = words_total;
    z0 = words_nz;
    repeat (1100) @(posedge clk);
    #2;
    check({name, "_nonzero_words"}, 32'(words_nz - z0), 32'd0);
    check({name, "_words_seen"}, 32'(words_total - t0 >= 3), 32'd1);
  endtask

  initial begin
    int rm, rs, rl, ones;
    logic pm, ps, pl;
    int t0, t1, t2;
    bit found;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clock taps and silent output with en=0
    rm = 0; rs = 0; rl = 0; ones = 0;
    @(posedge clk); #2;
    pm = mclk; ps = sck; pl = lrck;
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #2;
      if (!pm && mclk) rm++;
      if (!ps && sck) rs++;
      if (!pl && lrck) rl++;
      if (sdin) ones++;
      pm = mclk; ps = sck; pl = lrck;
    end
    check("mclk_rises", rm, 256);
    check("sck_rises", rs, 64);
    check("lrck_rises", rl, 2);
    check("sdin_ones_idle", ones, 0);

    // Tone with vol=3 and period 1001: high 500 cycles, low 501 cycles
    @(negedge clk);
    en = 1'b1; vol = 3'd3; note_div = 22'd1001;
    seen_3000 = 0; seen_d000 = 0;
    wait_edge(16'hD000, 16'h3000, t0);
    wait_edge(16'h3000, 16'hD000, t1);
    wait_edge(16'hD000, 16'h3000, t2);
    check("high_time", t1 - t0, 500);
    check("low_time", t2 - t1, 501);
    repeat (2000) @(posedge clk);
    #2;
    check("seen_3000", seen_3000, 1);
    check("seen_d000", seen_d000, 1);

    // Maximum volume
    @(negedge clk);
    vol = 3'd7; seen_7000 = 0; seen_9000 = 0;
    repeat (3000) @(posedge clk);
    #2;
    check("seen_7000", seen_7000, 1);
    check("seen_9000", seen_9000, 1);

    // A mid-period note change lets the old period finish first
    @(negedge clk);
    vol = 3'd3; note_div = 22'd1500;
    wait_edge(16'hD000, 16'h3000, t0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    note_div = 22'd700;
    wait_edge(16'hD000, 16'h3000, t1);
    wait_edge(16'hD000, 16'h3000, t2);
    check("old_period", t1 - t0, 1500);
    check("new_period", t2 - t1, 700);

    // Silence cases
    @(negedge clk);
    note_div = 22'd0;
    repeat (1300) @(posedge clk);
    quiet_window("div0");
    @(negedge clk);
    note_div = 22'd1001; vol = 3'd0;
    repeat (600) @(posedge clk);
    quiet_window("vol0");
    @(negedge clk);
    vol = 3'd3; en = 1'b0;
    repeat (600) @(posedge clk);
    quiet_window("en0");

    // Enabling starts the tone after a single clock
    @(negedge clk);
    en = 1'b1; note_div = 22'd1136;
    @(posedge clk); #2;
    check("start_1clk", dut.sample, 16'h3000);

    // Asynchronous reset in mid-frame at div_cnt = 300
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (m_edge % 512 == 300) found = 1;
    end
    check("found_div300", found, 1);
    #1;
    check("pre_rst_lrck_sck", {lrck, sck}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_outputs", {mclk, lrck, sck, sdin}, 4'b0000);
    check("rst_sample", dut.sample, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    check("post_rst_div1", {lrck, sck, mclk}, 3'b000);
    check("relatch_sample", dut.sample, 16'h3000);
    @(posedge clk); #2;
    check("post_rst_div2_mclk", mclk, 1'b1);
    repeat (1200) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule
